// File: rtl/mxu_pkg.sv
// Shared constants, state encoding and element-offset helper for the MXU
// stream controller and its neighbours.
package mxu_pkg;

  localparam int DW    = 16;
  localparam int N     = 3;
  localparam int MAT_W = N * N * DW;

  localparam int             IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  // Row-major bit offset of element (r,c) inside a packed matrix.
  function automatic int unsigned elem(input int unsigned r, input int unsigned c);
    return DW * (N * r + c);
  endfunction

endpackage

// File: rtl/mxu_stream_ctrl.sv
// Serial load of A/B operands for the 3x3 MXU, one-cycle result capture and
// serial drain of the nine result words.
module mxu_stream_ctrl
  import mxu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic [MAT_W-1:0] a_o,
  output logic [MAT_W-1:0] b_o,
  input  logic [MAT_W-1:0] res_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic             busy
);

  // Handshakes: a word moves on a rising edge where valid && ready are both
  // high and flush is low; ready/valid here depend on registered state only.

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [MAT_W-1:0]   res_q;
  logic [7:0]         off;
  logic               a_we, b_we, res_we;

  assign off = 8'(idx_q) * 8'(DW);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_we      = 1'b0;
    b_we      = 1'b0;
    res_we    = 1'b0;
    in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    out_valid = (state_q == DRAIN);
    out_last  = (state_q == DRAIN) && (idx_q == LAST_IDX);
    busy      = !((state_q == LOAD_A) && (idx_q == '0));
    out_data  = (state_q == DRAIN) ? res_q[off +: DW] : '0;

    if (flush) begin
      state_d = LOAD_A;
      idx_d   = '0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (in_valid) begin
            a_we = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = LOAD_B;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            b_we = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = COMPUTE;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        COMPUTE: begin
          res_we  = 1'b1;
          idx_d   = '0;
          state_d = DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = LOAD_A;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        default: begin
          idx_d   = '0;
          state_d = LOAD_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Operands persist after drain; the next load overwrites them word by word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_o   <= '0;
      b_o   <= '0;
      res_q <= '0;
    end else begin
      if (a_we)   a_o[off +: DW] <= in_data;
      if (b_we)   b_o[off +: DW] <= in_data;
      if (res_we) res_q          <= res_i;
    end
  end

  idx_range_a: assert property (@(posedge clk) disable iff (!rst_n) idx_q <= LAST_IDX);

endmodule

// File: tb/tb_mxu_stream_ctrl.sv
// Directed + randomized bench for mxu_stream_ctrl with a behavioural MXU
// beside it and a queue of expected result words.
module tb_mxu_stream_ctrl;
  import mxu_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic [MAT_W-1:0] a_o, b_o, res_i;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  // Matrix product modulo 2^16, straight from the definition.
  function automatic logic [MAT_W-1:0] matmul(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
    logic [MAT_W-1:0] m;
    logic [DW-1:0]    acc;
    logic [31:0]      prod;
    m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        acc = '0;
        for (int k = 0; k < N; k++) begin
          prod = 32'(a[elem(r, k) +: DW]) * 32'(b[elem(k, c) +: DW]);
          acc  = acc + prod[DW-1:0];
        end
        m[elem(r, c) +: DW] = acc;
      end
    return m;
  endfunction

  assign res_i = matmul(a_o, b_o);

  mxu_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .a_o(a_o), .b_o(b_o), .res_i(res_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_h(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_w(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MAT_W-1:0] rand_mat();
    logic [MAT_W-1:0] m;
    for (int k = 0; k < N * N; k++) m[DW*k +: DW] = DW'($urandom);
    return m;
  endfunction

  task automatic push_expected(input logic [MAT_W-1:0] m);
    for (int k = 0; k < N * N; k++) exp_q.push_back(m[DW*k +: DW]);
  endtask

  task automatic send_word(input logic [DW-1:0] d, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    chk_b("in_ready_timeout", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_words(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b,
                            input bit gaps, input int nwords);
    for (int k = 0; k < nwords; k++)
      send_word((k < 9) ? a[DW*k +: DW] : b[DW*(k-9) +: DW], gaps);
  endtask

  // Drains cnt words from the current DRAIN, checking each against exp_q.
  task automatic drain(input bit stall, input int cnt);
    logic [DW-1:0] e;
    for (int k = 0; k < cnt; k++) begin
      e = exp_q.pop_front();
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          out_ready = 1'b0;
          chk_b("stall_valid", out_valid, 1'b1);
          chk_h("stall_data", out_data, e);
          chk_b("stall_in_ready", in_ready, 1'b0);
          tick();
        end
      end
      chk_b("out_valid", out_valid, 1'b1);
      chk_h("out_data", out_data, e);
      chk_b("out_last", out_last, k == 8);
      chk_b("drain_in_ready", in_ready, 1'b0);
      chk_b("drain_busy", busy, 1'b1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    if (cnt == 9) begin
      chk_b("post_drain_valid", out_valid, 1'b0);
      chk_b("post_drain_in_ready", in_ready, 1'b1);
      chk_b("post_drain_busy", busy, 1'b0);
    end
  endtask

  // Full load; then COMPUTE for one cycle, out_valid the cycle after.
  task automatic load_and_compute(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b, input bit gaps);
    load_words(a, b, gaps, 18);
    chk_w("a_o_loaded", a_o, a);
    chk_w("b_o_loaded", b_o, b);
    chk_b("compute_valid", out_valid, 1'b0);
    chk_b("compute_in_ready", in_ready, 1'b0);
    chk_b("compute_busy", busy, 1'b1);
    tick();
    chk_b("first_valid_latency", out_valid, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MAT_W-1:0] a, b, b_prev, ident;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_h("rst_out_data", out_data, 16'h0);
    chk_b("rst_out_last", out_last, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_w("rst_a_o", a_o, '0);
    chk_w("rst_b_o", b_o, '0);

    // Identity: A = 1..9, B = I.
    for (int k = 0; k < 9; k++) a[DW*k +: DW] = DW'(k + 1);
    ident = '0;
    ident[elem(0, 0) +: DW] = 16'd1;
    ident[elem(1, 1) +: DW] = 16'd1;
    ident[elem(2, 2) +: DW] = 16'd1;
    for (int k = 0; k < 9; k++) exp_q.push_back(DW'(k + 1));
    load_and_compute(a, ident, 1'b0);
    drain(1'b0, 9);

    // Wrap: 3 * 0xFFFF mod 2^16.
    a = {9{16'h00FF}};
    b = {9{16'h0101}};
    for (int k = 0; k < 9; k++) exp_q.push_back(16'hFFFD);
    load_and_compute(a, b, 1'b0);
    drain(1'b0, 9);

    // Identity again under stalls, then random operands with and without stalls.
    for (int k = 0; k < 9; k++) exp_q.push_back(DW'(k + 1));
    for (int k = 0; k < 9; k++) a[DW*k +: DW] = DW'(k + 1);
    load_and_compute(a, ident, 1'b1);
    drain(1'b1, 9);
    for (int i = 0; i < 4; i++) begin
      a = rand_mat();
      b = rand_mat();
      push_expected(matmul(a, b));
      load_and_compute(a, b, i[0]);
      drain(i[0], 9);
    end
    b_prev = b;

    // Flush after 5 words of B; the word offered with flush is dropped.
    a = rand_mat();
    b = rand_mat();
    load_words(a, b, 1'b0, 14);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = ~b_prev[DW*5 +: DW];
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_b("flush_busy", busy, 1'b0);
    chk_b("flush_in_ready", in_ready, 1'b1);
    chk_b("flush_out_valid", out_valid, 1'b0);
    chk_h("flush_b4_kept", b_o[DW*4 +: DW], b[DW*4 +: DW]);
    chk_h("flush_b5_not_written", b_o[DW*5 +: DW], b_prev[DW*5 +: DW]);
    tick();
    chk_b("flush_idle_valid", out_valid, 1'b0);
    a = rand_mat();
    b = rand_mat();
    push_expected(matmul(a, b));
    load_and_compute(a, b, 1'b0);
    drain(1'b0, 9);

    // Flush in the same cycle as the DRAIN handshake of word 3.
    a = rand_mat();
    b = rand_mat();
    push_expected(matmul(a, b));
    load_and_compute(a, b, 1'b0);
    drain(1'b0, 3);
    chk_h("fh_word3", out_data, exp_q[0]);
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    chk_b("fh_out_valid", out_valid, 1'b0);
    chk_b("fh_busy", busy, 1'b0);
    chk_b("fh_in_ready", in_ready, 1'b1);
    chk_b("fh_out_last", out_last, 1'b0);

    // Asynchronous reset mid-DRAIN, checked before any clock edge.
    a = rand_mat();
    b = rand_mat();
    push_expected(matmul(a, b));
    load_and_compute(a, b, 1'b0);
    drain(1'b0, 2);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk_b("arst_out_valid", out_valid, 1'b0);
    chk_b("arst_in_ready", in_ready, 1'b1);
    chk_b("arst_busy", busy, 1'b0);
    chk_h("arst_out_data", out_data, 16'h0);
    chk_b("arst_out_last", out_last, 1'b0);
    chk_w("arst_a_o", a_o, '0);
    chk_w("arst_b_o", b_o, '0);
    tick();
    rst_n = 1'b1;
    tick();

    // Recovery after reset.
    a = rand_mat();
    b = rand_mat();
    push_expected(matmul(a, b));
    load_and_compute(a, b, 1'b1);
    drain(1'b1, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
